// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch controller: fetch state encodings,
// the sequential PC step and the NOP word loaded into IF/ID on reset/flush.
package inst_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] cur_pc);
    return cur_pc + PC_INC;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Instruction ROM bus: one request strobe with address, answered by ack/data.
// The fetch controller is the master, the ROM is the slave.
interface inst_fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              rom_cs;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [31:0]       rom_data;

  modport master (output rom_cs, output rom_addr, input rom_ack, input rom_data);
  modport slave  (input rom_cs, input rom_addr, output rom_ack, output rom_data);
endinterface

// File: rtl/inst_fetch_ctrl_fetch_watchdog.sv
// Fetch watchdog: counts cycles while enabled and raises a one-cycle expire
// pulse when the count reaches TIMEOUT-1, then restarts from zero.
module fetch_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  assign expire = enable && (count == LAST);

  // Count waiting cycles; any clear, idle period or expiry restarts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!enable || clear || expire) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch controller: owns the PC, keeps at most one ROM request in
// flight, presents the fetched word to IF/ID and stalls the pipeline while no
// instruction is ready. Optional request timeout: define IF_TIMEOUT_EN.
import inst_fetch_ctrl_pkg::*;

module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_en,
  input  logic                if_rst,
  input  logic                pc_redirect,
  input  logic [31:0]         pc_target,
  inst_fetch_ctrl_if.master   rom,
  output logic [31:0]         inst,
  output logic [31:0]         inst_pc,
  output logic                inst_valid,
  output logic                rom_stall,
  output logic                fetch_err
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("inst_fetch_ctrl: TIMEOUT must be at least 2");
  end

  fetch_state_t      state;
  logic [31:0]       pc;
  logic [31:0]       flush_pc;
  logic [31:0]       next_pc;
  logic              cs;
  logic [ADDR_W-1:0] addr;
  logic              ack_taken;
  logic              expire;

  // Drive the ROM strobe/address from the current state; HOLD launches the next fetch directly.
  always_comb begin
    next_pc = pc_redirect ? pc_target : next_seq_pc(inst_pc);
    cs      = 1'b0;
    addr    = pc[ADDR_W-1:0];
    case (state)
      ST_REQ:   cs = ~expire;
      ST_HOLD: begin
        cs   = if_en & ~if_rst;
        addr = next_pc[ADDR_W-1:0];
      end
      ST_FLUSH: begin
        cs   = ~expire;
        addr = flush_pc[ADDR_W-1:0];
      end
      default:  cs = 1'b0;
    endcase
  end

  assign ack_taken    = cs & rom.rom_ack;
  assign rom.rom_cs   = cs;
  assign rom.rom_addr = addr;
  assign rom_stall    = (state != ST_HOLD);

`ifdef IF_TIMEOUT_EN
  logic wd_enable;
  logic wd_clear;

  assign wd_enable = (state == ST_REQ) || (state == ST_FLUSH);
  assign wd_clear  = ack_taken | if_rst;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign fetch_err = expire;

  // Fetch FSM: a flush wins over normal progress and drains any request still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      flush_pc   <= RESET_PC;
      inst       <= NOP;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
    end else if (if_rst) begin
      pc         <= RESET_PC;
      inst       <= NOP;
      inst_valid <= 1'b0;
      if ((state == ST_REQ || state == ST_FLUSH) && !ack_taken && !expire) begin
        state <= ST_FLUSH;
        if (state == ST_REQ) begin
          flush_pc <= pc;
        end
      end else begin
        state <= ST_REQ;
      end
    end else begin
      case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          if (ack_taken) begin
            inst       <= rom.rom_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (if_en) begin
            pc <= next_pc;
            if (ack_taken) begin
              inst    <= rom.rom_data;
              inst_pc <= next_pc;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_FLUSH: begin
          if (ack_taken || expire) begin
            state <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
